frame_capture: RTL and testbench

Upstream stage of the stereo display path: converts a raw 640x480 8-bit luma pixel stream into the 100x100, 3-bit grayscale frame buffer that the VGA view stage reads. It decimates by 4 in both axes, crops a centred 100x100 window, and writes one buffer word per kept pixel in raster order (addresses 0..9999). Two instances are used, one per eye, each writing its own buffer.

---
 rtl/frame_capture.sv | 101 ++++++++++
 tb/tb_frame_capture.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/frame_capture.sv
// frame_capture: decimates a raw luma stream by DEC, crops a centred OUT_W x OUT_H window
// and writes 3-bit pixels to a frame buffer in raster order.
module frame_capture #(
  parameter int SRC_W = 640,
  parameter int SRC_H = 480,
  parameter int DEC   = 4,
  parameter int XOFF  = 30,
  parameter int YOFF  = 10,
  parameter int OUT_W = 100,
  parameter int OUT_H = 100
) (
  input  logic        vclk,
  input  logic        rst_n,
  input  logic        fs,
  input  logic        hvalid,
  input  logic        pvalid,
  input  logic [7:0]  pdata,
  input  logic        freeze,
  output logic        wrclk,
  output logic [15:0] wraddr,
  output logic [2:0]  wrdata,
  output logic        wren,
  output logic        frame_done,
  output logic        err
);
  typedef enum logic [1:0] {IDLE, CAPTURE, HOLD} state_t;
  localparam logic [9:0]  X_END  = 10'(SRC_W);
  localparam logic [8:0]  Y_END  = 9'(SRC_H);
  localparam logic [9:0]  X_DEC  = 10'(DEC);
  localparam logic [8:0]  Y_DEC  = 9'(DEC);
  localparam logic [9:0]  X_LO   = 10'(XOFF);
  localparam logic [9:0]  X_HI   = 10'(XOFF + OUT_W);
  localparam logic [8:0]  Y_LO   = 9'(YOFF);
  localparam logic [8:0]  Y_HI   = 9'(YOFF + OUT_H);
  localparam logic [15:0] A_LAST = 16'(OUT_W * OUT_H - 1);
  state_t      r_state;
  logic [9:0]  r_src_x;
  logic [8:0]  r_src_y;
  logic [15:0] r_addr;
  logic        r_hv;
  logic        r_last;
  logic        w_acc;
  logic        w_fall;
  logic        w_keep;
  logic [9:0]  w_dx;
  logic [8:0]  w_dy;
  assign wrclk  = vclk;
  assign w_acc  = hvalid && pvalid;
  assign w_fall = r_hv && !hvalid;
  assign w_dx   = r_src_x / X_DEC;
  assign w_dy   = r_src_y / Y_DEC;
  assign w_keep = (r_state == CAPTURE) && w_acc &&
                  (r_src_x % X_DEC == 0) && (r_src_y % Y_DEC == 0) &&
                  (w_dx >= X_LO) && (w_dx < X_HI) && (w_dy >= Y_LO) && (w_dy < Y_HI);
  always_ff @(posedge vclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_src_x    <= '0;
      r_src_y    <= '0;
      r_addr     <= '0;
      r_hv       <= 1'b0;
      r_last     <= 1'b0;
      wraddr     <= '0;
      wrdata     <= '0;
      wren       <= 1'b0;
      frame_done <= 1'b0;
      err        <= 1'b0;
    end else begin
      wren       <= 1'b0;
      r_last     <= 1'b0;
      frame_done <= r_last;
      r_hv       <= hvalid;
      if (fs) begin
        r_src_x <= '0;
        r_src_y <= '0;
        r_addr  <= '0;
        r_state <= freeze ? IDLE : CAPTURE;
        if (r_state == CAPTURE) err <= 1'b1;
      end else begin
        if (w_fall) begin
          if (r_src_x != X_END) err <= 1'b1;
          r_src_x <= '0;
          if (r_src_y != Y_END) r_src_y <= r_src_y + 9'd1;
        end else if (w_acc && r_src_x != '1) begin
          r_src_x <= r_src_x + 10'd1;
        end
        // frame_done trails the final write by one cycle via r_last
        if (w_keep) begin
          wren   <= 1'b1;
          wraddr <= r_addr;
          wrdata <= pdata[7:5];
          r_addr <= r_addr + 16'd1;
          if (r_addr == A_LAST) begin
            r_last  <= 1'b1;
            r_state <= HOLD;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_frame_capture.sv
// tb_frame_capture: directed scenario bench for frame_capture on a reduced geometry
// (128x32 source, 20x6 window at decimated origin 10,1 -> columns 40..116, rows 4..24).
module tb_frame_capture;
  localparam int SW = 128, SH = 32, D = 4, XO = 10, YO = 1, OW = 20, OH = 6, N = OW * OH;
  logic        vclk = 0, rst_n = 0, fs = 0, hvalid = 0, pvalid = 0, freeze = 0;
  logic [7:0]  pdata = 0;
  logic        wrclk, wren, frame_done, err;
  logic [15:0] wraddr;
  logic [2:0]  wrdata;
  int          checks = 0, errors = 0;
  int          wr_cnt = 0, done_cnt = 0;
  bit          prev_wren = 0, done_after_wren = 0;
  logic [15:0] log_addr [0:2047];
  logic [2:0]  log_data [0:2047];

  frame_capture #(.SRC_W(SW), .SRC_H(SH), .DEC(D), .XOFF(XO), .YOFF(YO), .OUT_W(OW), .OUT_H(OH)) u_dut (
    .vclk(vclk), .rst_n(rst_n), .fs(fs), .hvalid(hvalid), .pvalid(pvalid), .pdata(pdata),
    .freeze(freeze), .wrclk(wrclk), .wraddr(wraddr), .wrdata(wrdata), .wren(wren),
    .frame_done(frame_done), .err(err));

  always #5 vclk = ~vclk;

  always @(negedge vclk) begin
    if (wren) begin
      if (wr_cnt < 2048) begin
        log_addr[wr_cnt] = wraddr;
        log_data[wr_cnt] = wrdata;
      end
      wr_cnt++;
    end
    if (frame_done) begin
      done_cnt++;
      done_after_wren = prev_wren;
    end
    prev_wren = wren;
  end

  function automatic logic [2:0] exp_data(input int k);
    int sx;
    sx = (XO + k % OW) * D;
    return sx[7:5];
  endfunction

  task automatic send_fs(input bit frz);
    @(negedge vclk);
    fs = 1; freeze = frz;
    @(negedge vclk);
    fs = 0; freeze = 0;
  endtask

  task automatic send_line(input int len, input bit gap);
    repeat (2) @(negedge vclk);
    hvalid = 1;
    for (int px = 0; px < len;) begin
      pvalid = gap ? 1'($urandom_range(0, 1)) : 1'b1;
      pdata  = 8'(px);
      @(negedge vclk);
      if (pvalid) px++;
    end
    pvalid = 0; hvalid = 0;
    @(negedge vclk);
  endtask

  task automatic test_reset;
    int base;
    repeat (3) @(negedge vclk);
    checks++; if (wren !== 1'b0) begin errors++; $display("FAIL reset_wren: got %b expected 0", wren); end
    checks++; if (wraddr !== 16'd0) begin errors++; $display("FAIL reset_wraddr: got %0d expected 0", wraddr); end
    checks++; if (wrdata !== 3'd0) begin errors++; $display("FAIL reset_wrdata: got %0d expected 0", wrdata); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", frame_done); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
    rst_n = 1;
    #2 base = wr_cnt;
    for (int y = 0; y < 6; y++) send_line(SW, 0);
    #2;
    checks++; if (wr_cnt - base !== 0) begin errors++; $display("FAIL idle_no_write: got %0d writes expected 0", wr_cnt - base); end
  endtask

  task automatic test_full_frame;
    int base, dbase, bad;
    send_fs(0);
    #2 base = wr_cnt; dbase = done_cnt;
    for (int y = 0; y < SH; y++) send_line(SW, 0);
    repeat (4) @(negedge vclk);
    #2 bad = 0;
    for (int k = 0; k < N; k++)
      if (log_addr[base + k] !== 16'(k) || log_data[base + k] !== exp_data(k)) bad++;
    checks++; if (wr_cnt - base !== N) begin errors++; $display("FAIL full_count: got %0d expected %0d", wr_cnt - base, N); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL full_order: got %0d bad writes expected 0", bad); end
    checks++; if (log_data[base] !== 3'd1) begin errors++; $display("FAIL full_first_data: got %0d expected 1", log_data[base]); end
    checks++; if (log_data[base + N - 1] !== 3'd3) begin errors++; $display("FAIL full_last_data: got %0d expected 3", log_data[base + N - 1]); end
    checks++; if (done_cnt - dbase !== 1) begin errors++; $display("FAIL full_done_count: got %0d expected 1", done_cnt - dbase); end
    checks++; if (done_after_wren !== 1'b1) begin errors++; $display("FAIL full_done_timing: got %b expected 1", done_after_wren); end
    checks++; if (wraddr !== 16'(N - 1) || wren !== 1'b0) begin errors++; $display("FAIL full_hold_addr: got %0d/%b expected %0d/0", wraddr, wren, N - 1); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL full_err: got %b expected 0", err); end
    #2 base = wr_cnt;
    for (int y = 0; y < 6; y++) send_line(SW, 0);
    #2;
    checks++; if (wr_cnt - base !== 0) begin errors++; $display("FAIL hold_no_write: got %0d writes expected 0", wr_cnt - base); end
  endtask

  task automatic test_freeze;
    int base, dbase;
    send_fs(1);
    #2 base = wr_cnt; dbase = done_cnt;
    for (int y = 0; y < SH; y++) send_line(SW, 0);
    repeat (4) @(negedge vclk);
    #2;
    checks++; if (wr_cnt - base !== 0) begin errors++; $display("FAIL freeze_count: got %0d expected 0", wr_cnt - base); end
    checks++; if (done_cnt - dbase !== 0) begin errors++; $display("FAIL freeze_done: got %0d expected 0", done_cnt - dbase); end
    send_fs(0);
    #2 base = wr_cnt;
    for (int y = 0; y < SH; y++) send_line(SW, 0);
    repeat (4) @(negedge vclk);
    #2;
    checks++; if (wr_cnt - base !== N) begin errors++; $display("FAIL unfreeze_count: got %0d expected %0d", wr_cnt - base, N); end
    checks++; if (log_addr[base] !== 16'd0 || log_addr[base + N - 1] !== 16'(N - 1)) begin errors++; $display("FAIL unfreeze_addr: got %0d..%0d expected 0..%0d", log_addr[base], log_addr[base + N - 1], N - 1); end
  endtask

  task automatic test_gapped;
    int base, bad;
    send_fs(0);
    #2 base = wr_cnt;
    for (int y = 0; y < SH; y++) send_line(SW, 1);
    repeat (4) @(negedge vclk);
    #2 bad = 0;
    for (int k = 0; k < N; k++)
      if (log_addr[base + k] !== 16'(k) || log_data[base + k] !== exp_data(k)) bad++;
    checks++; if (wr_cnt - base !== N) begin errors++; $display("FAIL gap_count: got %0d expected %0d", wr_cnt - base, N); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL gap_order: got %0d bad writes expected 0", bad); end
  endtask

  task automatic test_fs_midframe;
    int base, dbase;
    send_fs(0);
    #2 base = wr_cnt;
    for (int y = 0; y <= 12; y++) send_line(SW, 0);
    #2;
    checks++; if (wr_cnt - base !== 60) begin errors++; $display("FAIL mid_partial: got %0d expected 60", wr_cnt - base); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL mid_err_before: got %b expected 0", err); end
    send_fs(0);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL mid_err_after: got %b expected 1", err); end
    #2 base = wr_cnt; dbase = done_cnt;
    for (int y = 0; y < SH; y++) send_line(SW, 0);
    repeat (4) @(negedge vclk);
    #2;
    checks++; if (log_addr[base] !== 16'd0) begin errors++; $display("FAIL mid_restart_addr: got %0d expected 0", log_addr[base]); end
    checks++; if (wr_cnt - base !== N) begin errors++; $display("FAIL mid_count: got %0d expected %0d", wr_cnt - base, N); end
    checks++; if (done_cnt - dbase !== 1) begin errors++; $display("FAIL mid_done: got %0d expected 1", done_cnt - dbase); end
  endtask

  task automatic test_reset_mid;
    int base;
    bit seen;
    send_fs(0);
    for (int y = 0; y < 12; y++) send_line(SW, 0);
    repeat (2) @(negedge vclk);
    hvalid = 1; pvalid = 1; seen = 0;
    for (int i = 0; i < SW && !seen; i++) begin
      pdata = 8'(i);
      @(negedge vclk);
      if (wren) seen = 1;
    end
    #1 rst_n = 0;
    #1;
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL rstmid_write_seen: got %b expected 1", seen); end
    checks++; if (wren !== 1'b0 || wraddr !== 16'd0) begin errors++; $display("FAIL rstmid_async: got wren=%b addr=%0d expected 0/0", wren, wraddr); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rstmid_err: got %b expected 0", err); end
    hvalid = 0; pvalid = 0;
    repeat (3) @(negedge vclk);
    rst_n = 1;
    #2 base = wr_cnt;
    for (int y = 0; y < 8; y++) send_line(SW, 0);
    #2;
    checks++; if (wr_cnt - base !== 0) begin errors++; $display("FAIL rstmid_no_write: got %0d expected 0", wr_cnt - base); end
    send_fs(0);
    #2 base = wr_cnt;
    for (int y = 0; y < SH; y++) send_line(SW, 0);
    repeat (4) @(negedge vclk);
    #2;
    checks++; if (wr_cnt - base !== N || log_addr[base] !== 16'd0) begin errors++; $display("FAIL rstmid_recover: got %0d writes from %0d expected %0d from 0", wr_cnt - base, log_addr[base], N); end
  endtask

  task automatic test_short_line;
    int base;
    send_fs(0);
    #2 base = wr_cnt;
    for (int y = 0; y < SH; y++) begin
      send_line(y == 9 ? SW - 40 : SW, 0);
      if (y == 8) begin
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL short_err_before: got %b expected 0", err); end
      end
      if (y == 9) begin
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL short_err_after: got %b expected 1", err); end
      end
    end
    repeat (4) @(negedge vclk);
    #2;
    checks++; if (wr_cnt - base !== N) begin errors++; $display("FAIL short_count: got %0d expected %0d", wr_cnt - base, N); end
    send_fs(0);
    for (int y = 0; y < SH; y++) send_line(SW, 0);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL short_err_sticky: got %b expected 1", err); end
  endtask

  initial begin
    test_reset;
    test_full_frame;
    test_freeze;
    test_gapped;
    test_fs_midframe;
    test_reset_mid;
    test_short_line;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
